// File: rtl/encode.sv
// Instruction encoder: packs decoded fields into the 27-bit instruction word
// and buffers it through a two-entry skid stage. Define ENC_CHECK_EN to build the legality checks.
module encode #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_fmt,
   input  logic [3:0]       in_rd,
   input  logic [3:0]       in_rm,
   input  logic [3:0]       in_func,
   input  logic [3:0]       in_ra,
   input  logic [3:0]       in_rb,
   input  logic             in_narith,
   input  logic [1:0]       in_lflags,
   input  logic [20:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [26:0]      out_instr,
   output logic             out_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] enc_count
);

   localparam logic [1:0] FMT_R = 2'd0;
   localparam logic [1:0] FMT_I = 2'd1;
   localparam logic [1:0] FMT_M = 2'd2;
   localparam logic [1:0] FMT_L = 2'd3;

   // Buffer occupancy: nothing, output register only, output plus skid.
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   state_t           state_q, state_d;
   logic             accept, drain;
   logic             ld_out_new, ld_out_skid, ld_skid;
   logic [26:0]      enc_word;
   logic [26:0]      out_instr_q, skid_instr_q;
   logic [CNT_W-1:0] cnt_q;

   // Handshakes derive from the state register only, so out_ready never
   // reaches in_ready combinationally.
   assign accept = in_valid  & (state_q != S_FULL);
   assign drain  = out_ready & (state_q != S_EMPTY);

   always_comb begin
      enc_word = '0;
      case (in_fmt)
         FMT_R: begin
            enc_word[26:23] = in_rd;
            enc_word[20]    = in_narith;
            enc_word[18:15] = in_func;
            enc_word[14:11] = in_ra;
            enc_word[10:7]  = in_rb;
         end
         FMT_I: begin
            enc_word[26:23] = in_rd;
            enc_word[20]    = in_narith;
            enc_word[18:15] = in_func;
            enc_word[14:11] = in_ra;
            enc_word[10:0]  = in_imm[10:0];
         end
         FMT_M: begin
            enc_word[26:23] = in_func;
            enc_word[20:19] = 2'b11;
            enc_word[18:15] = in_rm;
            enc_word[14:11] = in_ra;
            if (in_func[3]) enc_word[10:0] = in_imm[10:0];
            else            enc_word[10:7] = in_rb;
         end
         default: begin
            enc_word[26:23] = in_rd;
            enc_word[22:21] = in_lflags;
            enc_word[20:0]  = in_imm;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (accept) state_d = S_ONE;
         S_ONE: begin
            if (accept && !drain)      state_d = S_FULL;
            else if (drain && !accept) state_d = S_EMPTY;
         end
         S_FULL:  if (drain) state_d = S_ONE;
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      out_valid   = (state_q != S_EMPTY);
      in_ready    = (state_q != S_FULL);
      ld_out_new  = accept & ((state_q == S_EMPTY) | drain);
      ld_out_skid = drain & (state_q == S_FULL);
      ld_skid     = accept & (state_q == S_ONE) & ~drain;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_instr_q  <= '0;
         skid_instr_q <= '0;
      end else begin
         if (ld_out_new)       out_instr_q <= enc_word;
         else if (ld_out_skid) out_instr_q <= skid_instr_q;
         if (ld_skid)          skid_instr_q <= enc_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)        cnt_q <= '0;
      else if (drain) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign out_instr = out_instr_q;
   assign enc_count = cnt_q;

`ifdef ENC_CHECK_EN
   logic illegal;
   logic out_err_q, skid_err_q, sticky_q;

   // Illegal words are still encoded; they only carry the error tag.
   always_comb begin
      illegal = 1'b0;
      case (in_fmt)
         FMT_R:   illegal = in_func[3];
         FMT_I:   illegal = ~in_func[3];
         FMT_L:   illegal = (in_lflags == 2'b00);
         default: illegal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_err_q  <= 1'b0;
         skid_err_q <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         if (ld_out_new)       out_err_q <= illegal;
         else if (ld_out_skid) out_err_q <= skid_err_q;
         if (ld_skid)          skid_err_q <= illegal;
         if (accept && illegal) sticky_q <= 1'b1;
      end
   end

   assign out_err    = out_err_q;
   assign err_sticky = sticky_q;
`else
   assign out_err    = 1'b0;
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_encode.sv
// Directed bench for encode: a negedge monitor scoreboards every emitted word,
// the main sequence checks latency, backpressure, count wrap and reset.
module tb_encode;
   localparam int CNT_W = 4;
`ifdef ENC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [1:0]       in_fmt;
   logic [3:0]       in_rd, in_rm, in_func, in_ra, in_rb;
   logic             in_narith;
   logic [1:0]       in_lflags;
   logic [20:0]      in_imm;
   logic             out_valid, out_ready;
   logic [26:0]      out_instr;
   logic             out_err, err_sticky;
   logic [CNT_W-1:0] enc_count;

   typedef struct packed {
      logic [26:0] instr;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   encode #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_rd(in_rd), .in_rm(in_rm), .in_func(in_func),
      .in_ra(in_ra), .in_rb(in_rb), .in_narith(in_narith), .in_lflags(in_lflags),
      .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err), .err_sticky(err_sticky),
      .enc_count(enc_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] f, input logic [3:0] rd, rm, fn, ra, rb,
                                  input logic na, input logic [1:0] lf, input logic [20:0] im);
      exp_t e;
      case (f)
         2'd0: e.instr = {rd, 2'b00, na, 1'b0, fn, ra, rb, 7'b0};
         2'd1: e.instr = {rd, 2'b00, na, 1'b0, fn, ra, im[10:0]};
         2'd2: e.instr = fn[3] ? {fn, 4'b0011, rm, ra, im[10:0]} : {fn, 4'b0011, rm, ra, rb, 7'b0};
         default: e.instr = {rd, lf, im};
      endcase
      e.err = CHK && ((f == 2'd0 && fn[3]) || (f == 2'd1 && !fn[3]) || (f == 2'd3 && lf == 2'b00));
      return e;
   endfunction

   // Inputs change #1 after posedge, so at negedge they already show what the next edge will do.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_word", {31'b0, out_valid}, 32'd0);
            else begin
               chk("sb_instr", {5'b0, out_instr}, {5'b0, q[0].instr});
               chk("sb_err", {31'b0, out_err}, {31'b0, q[0].err});
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready)
            q.push_back(model(in_fmt, in_rd, in_rm, in_func, in_ra, in_rb, in_narith, in_lflags, in_imm));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] f, input logic [3:0] rd, rm, fn, ra, rb,
                          input logic na, input logic [1:0] lf, input logic [20:0] im);
      in_fmt = f; in_rd = rd; in_rm = rm; in_func = fn; in_ra = ra; in_rb = rb;
      in_narith = na; in_lflags = lf; in_imm = im;
      in_valid = 1'b1;
   endtask

   task automatic send(input logic [1:0] f, input logic [3:0] rd, rm, fn, ra, rb,
                       input logic na, input logic [1:0] lf, input logic [20:0] im);
      int budget = 20;
      set_req(f, rd, rm, fn, ra, rb, na, lf, im);
      while (!in_ready && budget > 0) begin cyc(); budget--; end
      if (budget == 0) chk("send_timeout", {31'b0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_req(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 21'd0);
      in_valid = 1'b0;
      cyc(); cyc();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_instr", {5'b0, out_instr}, 32'd0);
      chk("rst_out_err", {31'b0, out_err}, 32'd0);
      chk("rst_sticky", {31'b0, err_sticky}, 32'd0);
      chk("rst_count", {28'b0, enc_count}, 32'd0);
      rst = 1'b0;
      cyc();

      // R word; unused rm/lflags/imm carry garbage that must be ignored
      send(2'd0, 4'd3, 4'hA, 4'b0010, 4'd5, 4'd6, 1'b0, 2'b11, 21'h1FFFFF);
      chk("r_valid", {31'b0, out_valid}, 32'd1);
      chk("r_instr", {5'b0, out_instr}, 32'h1812B00);
      chk("r_err", {31'b0, out_err}, 32'd0);
      cyc();
      chk("r_count", {28'b0, enc_count}, 32'd1);
      chk("r_drained", {31'b0, out_valid}, 32'd0);

      send(2'd1, 4'd2, 4'h7, 4'b1001, 4'd4, 4'hF, 1'b1, 2'b01, 21'h1FF5A5);
      chk("i_instr", {5'b0, out_instr}, 32'h114A5A5);
      chk("i_err", {31'b0, out_err}, 32'd0);
      cyc();

      send(2'd3, 4'd1, 4'h5, 4'hF, 4'hE, 4'hD, 1'b1, 2'b10, 21'h12345);
      chk("l_instr", {5'b0, out_instr}, 32'h0C12345);
      chk("l_err", {31'b0, out_err}, 32'd0);
      chk("l_sticky_clear", {31'b0, err_sticky}, 32'd0);
      cyc();
      send(2'd3, 4'd1, 4'h5, 4'hF, 4'hE, 4'hD, 1'b1, 2'b00, 21'h12345);
      chk("lbad_instr", {5'b0, out_instr}, 32'h0812345);
      chk("lbad_err", {31'b0, out_err}, {31'b0, CHK});
      chk("lbad_sticky", {31'b0, err_sticky}, {31'b0, CHK});
      cyc();
      chk("sticky_holds", {31'b0, err_sticky}, {31'b0, CHK});

      send(2'd2, 4'hF, 4'd7, 4'b1100, 4'd2, 4'hB, 1'b1, 2'b01, 21'h1FF7FF);
      chk("m_imm_instr", {5'b0, out_instr}, 32'h61B97FF);
      cyc();
      send(2'd2, 4'hF, 4'd7, 4'b0100, 4'd2, 4'd9, 1'b1, 2'b01, 21'h1FF7FF);
      chk("m_rb_instr", {5'b0, out_instr}, 32'h21B9480);
      cyc();
      send(2'd0, 4'd1, 4'd0, 4'b1000, 4'd1, 4'd1, 1'b0, 2'b00, 21'd0);
      chk("rbad_err", {31'b0, out_err}, {31'b0, CHK});
      cyc();
      chk("count_7", {28'b0, enc_count}, 32'd7);

      // Backpressure: three requests against a stalled consumer
      pulse_reset();
      out_ready = 1'b0;
      set_req(2'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'b01, 21'h00001);
      chk("bp_rdy_a", {31'b0, in_ready}, 32'd1);
      cyc();
      set_req(2'd3, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'b01, 21'h00002);
      chk("bp_rdy_b", {31'b0, in_ready}, 32'd1);
      cyc();
      set_req(2'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'b01, 21'h00003);
      chk("bp_full", {31'b0, in_ready}, 32'd0);
      cyc(); cyc();
      chk("bp_still_full", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_a", {5'b0, out_instr}, 32'h0A00001);
      out_ready = 1'b1;
      cyc();
      chk("bp_b", {5'b0, out_instr}, 32'h1200002);
      chk("bp_rdy_again", {31'b0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("bp_c", {5'b0, out_instr}, 32'h1A00003);
      chk("bp_c_valid", {31'b0, out_valid}, 32'd1);
      cyc();
      chk("bp_empty", {31'b0, out_valid}, 32'd0);
      chk("bp_count", {28'b0, enc_count}, 32'd3);

      // Wrap: 17 back-to-back handoffs on a 4-bit counter
      pulse_reset();
      for (int i = 0; i < 17; i++) begin
         set_req(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 21'($urandom));
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("wrap_count", {28'b0, enc_count}, 32'd1);

      // Reset with both entries holding words, one of them illegal
      out_ready = 1'b0;
      set_req(2'd0, 4'd4, 4'd0, 4'b1111, 4'd1, 4'd2, 1'b0, 2'b00, 21'd0);
      cyc();
      set_req(2'd3, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 21'h00055);
      cyc();
      in_valid = 1'b0;
      chk("pre_rst_full", {31'b0, in_ready}, 32'd0);
      rst = 1'b1; out_ready = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
      chk("mid_rst_count", {28'b0, enc_count}, 32'd0);
      chk("mid_rst_sticky", {31'b0, err_sticky}, 32'd0);
      repeat (4) cyc();
      chk("post_rst_count", {28'b0, enc_count}, 32'd0);
      chk("sb_drained", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
